// File: rtl/pc_fetch_ctrl.sv
// PC fetch controller: drives the instruction memory address, flushes on redirect.
// Option: define FETCH_MISALIGN_TRAP_EN to trap (and halt) on misaligned redirects.
module pc_fetch_ctrl #(
  parameter int unsigned IMEM_BYTES = 64,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  input  logic [31:0] inst_in,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic        halted
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        trap
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [31:0] MEM_END = 32'(IMEM_BYTES);
  localparam logic [31:0] LAST_PC = MEM_END - 32'd4;

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_n;
  logic [31:0] id_pc_n;
  logic        id_valid_n;
  logic [31:0] tgt;
  logic [31:0] inc_pc;
  logic        bad_align;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        trap_q, trap_n;
  assign trap = trap_q;
`endif

  assign id_inst = inst_in;
  assign halted  = (state == HALT);
  assign pc      = (stall && !redirect_valid) ? id_pc : fetch_pc;
  assign tgt     = redirect_target & ~32'h3;
  assign inc_pc  = (fetch_pc + 32'd4 == MEM_END) ? fetch_pc
                                                 : fetch_pc + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bad_align = |redirect_target[1:0];
`else
  assign bad_align = 1'b0;
`endif

  // State and fetch registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      id_pc    <= RESET_PC;
      id_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q   <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_n;
      id_pc    <= id_pc_n;
      id_valid <= id_valid_n;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q   <= trap_n;
`endif
    end
  end

  // Next-state: redirect beats stall; last word is shown once, then halt.
  always_comb begin
    state_n    = state;
    fetch_n    = fetch_pc;
    id_pc_n    = id_pc;
    id_valid_n = id_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_n     = trap_q;
`endif
    unique case (state)
      BOOT: begin
        state_n    = RUN;
        fetch_n    = inc_pc;
        id_pc_n    = fetch_pc;
        id_valid_n = 1'b1;
      end
      RUN, HALT: begin
        if (redirect_valid) begin
          id_valid_n = 1'b0;
          if (bad_align) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_n  = 1'b1;
`endif
            state_n = HALT;
          end else if (tgt >= MEM_END) begin
            state_n = HALT;
          end else begin
            fetch_n = tgt;
            state_n = RUN;
          end
        end else if (state == HALT || stall) begin
          state_n = state;
        end else if (id_valid && id_pc == LAST_PC) begin
          state_n    = HALT;
          id_valid_n = 1'b0;
        end else begin
          id_pc_n    = fetch_pc;
          fetch_n    = inc_pc;
          id_valid_n = 1'b1;
        end
      end
      default: begin
        state_n    = BOOT;
        id_valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl (IMEM_BYTES=64, RESET_PC=0).
// Memory model returns 0xA000_0000 | address, registered one cycle.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic [31:0] inst_in;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        halted;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        trap;
`endif

  int errors = 0;
  int checks = 0;

  pc_fetch_ctrl #(
    .IMEM_BYTES(64),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .pc(pc),
    .inst_in(inst_in),
    .id_inst(id_inst),
    .id_pc(id_pc),
    .id_valid(id_valid),
    .halted(halted)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .trap(trap)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) inst_in <= 32'hA000_0000 | pc;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic [31:0] a);
    chk({tag, "_pc"}, id_pc, a);
    chk({tag, "_valid"}, {31'b0, id_valid}, 32'd1);
    chk({tag, "_inst"}, id_inst, 32'hA000_0000 | a);
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    inst_in = 32'h0;
    step();
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_idpc", id_pc, 32'd0);
    chk("rst_pc", pc, 32'd0);
    rst = 1'b0;
    #1;
    chk("boot_valid", {31'b0, id_valid}, 32'd0);
    chk("boot_pc", pc, 32'd0);

    step();
    chk_id("run0", 32'd0);
    chk("run0_fpc", pc, 32'd4);
    step();
    chk_id("run4", 32'd4);
    step();
    chk_id("run8", 32'd8);

    stall = 1'b1;
    #1;
    chk("stall_pc", pc, 32'd8);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_id("stall8", 32'd8);
    end
    stall = 1'b0;
    step();
    chk_id("unstall12", 32'd12);
    step();
    chk_id("run16", 32'd16);

    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'd40;
    #1;
    chk("redir_pc", pc, 32'd20);
    step();
    stall = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("redir_flush", {31'b0, id_valid}, 32'd0);
    chk("redir_tpc", pc, 32'd40);
    step();
    chk_id("redir40", 32'd40);
    step();
    chk_id("run44", 32'd44);

    redirect_valid = 1'b1;
    redirect_target = 32'd22;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_trap", {31'b0, trap}, 32'd1);
    chk("mis_halt", {31'b0, halted}, 32'd1);
    chk("mis_valid", {31'b0, id_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_target = 32'd20;
    step();
    redirect_valid = 1'b0;
    step();
    chk_id("mis_resume20", 32'd20);
    chk("mis_trap_sticky", {31'b0, trap}, 32'd1);
`else
    chk("mis_flush", {31'b0, id_valid}, 32'd0);
    step();
    chk_id("mis20", 32'd20);
`endif

    for (int a = 24; a <= 60; a += 4) begin
      step();
      chk_id("free", 32'(a));
    end
    chk("end_pc", pc, 32'd60);
    step();
    chk("end_halt", {31'b0, halted}, 32'd1);
    chk("end_valid", {31'b0, id_valid}, 32'd0);
    step();
    chk("end_hold_halt", {31'b0, halted}, 32'd1);
    chk("end_hold_pc", pc, 32'd60);

    redirect_valid = 1'b1;
    redirect_target = 32'd0;
    step();
    redirect_valid = 1'b0;
    chk("restart_halt", {31'b0, halted}, 32'd0);
    chk("restart_flush", {31'b0, id_valid}, 32'd0);
    step();
    chk_id("restart0", 32'd0);

    redirect_valid = 1'b1;
    redirect_target = 32'd70;
    step();
    redirect_valid = 1'b0;
    chk("oor_halt", {31'b0, halted}, 32'd1);
    chk("oor_valid", {31'b0, id_valid}, 32'd0);

    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'd8;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_halt", {31'b0, halted}, 32'd0);
    chk("arst_valid", {31'b0, id_valid}, 32'd0);
    chk("arst_idpc", id_pc, 32'd0);
    step();
    stall = 1'b0;
    redirect_valid = 1'b0;
    rst = 1'b0;
    step();
    chk_id("rerun0", 32'd0);
    step();
    chk_id("rerun4", 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter IMEM_BYTES, default 64, byte size of the instruction memory; SHALL be a multiple of 4, at least 8.
REQ-002 Parameter RESET_PC, default 32'h0, first fetch address after reset; SHALL be word-aligned and below IMEM_BYTES.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 stall  input  1  decode cannot accept; hold the current instruction.
REQ-006 redirect_valid  input  1  branch/jump taken this cycle.
REQ-007 redirect_target  input  32  byte address of the new fetch stream.
REQ-008 pc  output  32  byte address driven to the instruction memory's pc input.
REQ-009 inst_in  input  32  registered instruction from the instruction memory: the word at the pc driven in the previous cycle.
REQ-010 id_inst  output  32  instruction presented to decode; equals inst_in.
REQ-011 id_pc  output  32  address of id_inst.
REQ-012 id_valid  output  1  id_inst/id_pc hold a valid instruction on the correct path.
REQ-013 halted  output  1  fetch stopped (end of memory or bad target).
REQ-014 trap  output  1  misaligned redirect seen; present only with FETCH_MISALIGN_TRAP_EN.

Function
REQ-015 Internal register fetch_pc; pc SHALL equal id_pc when stall=1 and redirect_valid=0, else fetch_pc.
REQ-016 States: BOOT, RUN, HALT; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-017 BOOT: fetch_pc=RESET_PC, id_valid=0; at the BOOT->RUN edge fetch_pc becomes RESET_PC+4, id_pc becomes RESET_PC, and id_valid becomes 1.
REQ-018 RUN, no stall, no redirect: per edge, id_pc<=fetch_pc, fetch_pc<=fetch_pc+4, id_valid<=1; fetch latency one cycle, throughput one word per cycle.
REQ-019 RUN, stall=1, no redirect: fetch_pc, id_pc, id_valid SHALL hold; the memory re-reads id_pc, so id_inst is unchanged next cycle.
REQ-020 Redirect: redirect_valid=1 has priority over stall; on that edge fetch_pc<=target, id_valid<=0 (wrong-path word flushed); the target word appears with id_valid=1 two cycles after the redirect cycle.
REQ-021 End of memory: when an edge would set fetch_pc to IMEM_BYTES, fetch_pc SHALL hold instead and the state SHALL go to HALT after the last word (IMEM_BYTES-4) has been presented with id_valid=1 for one non-stalled cycle.
REQ-022 Redirect with target>=IMEM_BYTES SHALL go to HALT directly with id_valid=0.
REQ-023 HALT: halted=1, id_valid=0, pc held; exits only on reset or an in-range, accepted redirect, which re-enters RUN under REQ-020.
REQ-024 Address arithmetic is 32-bit unsigned; no wrap-around to 0 at the end of memory.

Reset
REQ-025 While rst=1, asynchronously: state=BOOT, fetch_pc=RESET_PC, id_pc=RESET_PC, id_valid=0, halted=0, trap=0.
REQ-026 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation; no redirect is remembered across reset.

Configuration
REQ-027 Macro FETCH_MISALIGN_TRAP_EN defined: a redirect with target[1:0]!=0 SHALL set trap=1 (sticky until reset), go to HALT, and present no instruction.
REQ-028 Macro undefined: no trap port; target[1:0] SHALL be forced to 2'b00 and the redirect handled normally.

Verification
REQ-029 Reset release, no stall -> id_pc sequence 0,4,8,... with id_valid=1 starting on the second cycle after release.
REQ-030 Stall for 3 cycles while id_pc=8 -> id_pc=8, id_inst and id_valid=1 unchanged for 3 cycles; id_pc=12 appears on the cycle after stall drops.
REQ-031 Redirect to 20 while id_pc=4, stall=1 -> next cycle id_valid=0; the following cycle id_pc=20, id_valid=1.
REQ-032 Free-run with IMEM_BYTES=64 -> id_pc=60 valid for one cycle, then halted=1, id_valid=0; redirect to 0 -> restarts at id_pc=0.
REQ-033 Redirect to 70 -> halted=1 next cycle, id_valid=0.
REQ-034 Redirect to 22: with FETCH_MISALIGN_TRAP_EN -> trap=1, halted=1; without -> id_pc=20 valid.
